sodor5_isa_ref_model: RTL and testbench

- Architectural (ISA-level) golden model of the Sodor 5-stage RV32I core, restricted to OP-IMM, LOAD and STORE.
- Executes one externally supplied instruction per clock against its own 32-entry register file and 16-word data memory.
- Publishes a registered commit trace; the lockstep verification harness compares this trace against the pipelined core.

---
 rtl/sodor5_isa_pkg.sv | 51 +++++
 rtl/sodor5_isa_alu.sv | 32 +++
 rtl/sodor5_isa_ref_model.sv | 169 ++++++++++++++++
 tb/tb_sodor5_isa_ref_model.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sodor5_isa_pkg.sv
// Shared constants, commit-trace record and immediate decoders for the
// Sodor RV32I (OP-IMM / LOAD / STORE) architectural reference model.
package sodor5_isa_pkg;

   localparam int NUM_REGS   = 32;
   localparam int WORD_SIZE  = 32;
   localparam int DMEM_WORDS = 16;

   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_ADDI  = 3'd0;
   localparam logic [2:0] F3_SLLI  = 3'd1;
   localparam logic [2:0] F3_SLTI  = 3'd2;
   localparam logic [2:0] F3_SLTIU = 3'd3;
   localparam logic [2:0] F3_XORI  = 3'd4;
   localparam logic [2:0] F3_SRXI  = 3'd5;
   localparam logic [2:0] F3_ORI   = 3'd6;
   localparam logic [2:0] F3_ANDI  = 3'd7;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   localparam logic [2:0] F3_SB = 3'd0;
   localparam logic [2:0] F3_SH = 3'd1;
   localparam logic [2:0] F3_SW = 3'd2;

   typedef struct packed {
      logic                 valid;
      logic [WORD_SIZE-1:0] pc;
      logic                 wen;
      logic [4:0]           rd;
      logic [WORD_SIZE-1:0] wdata;
      logic                 store_en;
      logic [WORD_SIZE-1:0] store_addr;
      logic [WORD_SIZE-1:0] store_wdata;
   } commit_t;

   function automatic logic [WORD_SIZE-1:0] imm_i(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:20]};
   endfunction

   function automatic logic [WORD_SIZE-1:0] imm_s(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:25], instr[11:7]};
   endfunction

endpackage

// File: rtl/sodor5_isa_alu.sv
// Combinational OP-IMM ALU. alt is instr[30] and only matters for the
// right shifts (SRAI vs SRLI); the shift amount is the low five imm bits.
module sodor5_isa_alu
   import sodor5_isa_pkg::*;
(
   input  logic [2:0]           funct3,
   input  logic                 alt,
   input  logic [WORD_SIZE-1:0] a,
   input  logic [WORD_SIZE-1:0] imm,
   output logic [WORD_SIZE-1:0] result
);

   logic [4:0] shamt;

   assign shamt = imm[4:0];

   always_comb begin
      result = '0;
      case (funct3)
         F3_ADDI:  result = a + imm;
         F3_SLLI:  result = a << shamt;
         F3_SLTI:  result = {{(WORD_SIZE-1){1'b0}}, ($signed(a) < $signed(imm))};
         F3_SLTIU: result = {{(WORD_SIZE-1){1'b0}}, (a < imm)};
         F3_XORI:  result = a ^ imm;
         F3_SRXI:  result = alt ? WORD_SIZE'($signed(a) >>> shamt) : (a >> shamt);
         F3_ORI:   result = a | imm;
         F3_ANDI:  result = a & imm;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/sodor5_isa_ref_model.sv
// Single-cycle architectural model: executes one instruction per edge against
// its own register file and data memory and publishes a registered commit trace.
module sodor5_isa_ref_model
   import sodor5_isa_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instr,
   output logic                 commit_valid,
   output logic [WORD_SIZE-1:0] commit_pc,
   output logic                 commit_wen,
   output logic [4:0]           commit_rd,
   output logic [WORD_SIZE-1:0] commit_wdata,
   output logic                 store_en,
   output logic [WORD_SIZE-1:0] store_addr,
   output logic [WORD_SIZE-1:0] store_wdata
);

   localparam int DAW = $clog2(DMEM_WORDS);

   // Neither array is reset; harnesses preload them by hierarchical name.
   logic [WORD_SIZE-1:0] regfile [NUM_REGS];
   logic [WORD_SIZE-1:0] mem     [DMEM_WORDS];

   logic [WORD_SIZE-1:0] pc_reg;
   commit_t              commit_reg;

   logic [6:0]           opcode;
   logic [4:0]           rd;
   logic [4:0]           rs1;
   logic [4:0]           rs2;
   logic [2:0]           funct3;
   logic [WORD_SIZE-1:0] rs1_val;
   logic [WORD_SIZE-1:0] rs2_val;
   logic [WORD_SIZE-1:0] imm_i_val;
   logic [WORD_SIZE-1:0] imm_s_val;
   logic [WORD_SIZE-1:0] alu_result;

   logic [WORD_SIZE-1:0] eff_addr;
   logic [DAW-1:0]       word_idx;
   logic [4:0]           byte_off;
   logic [4:0]           half_off;
   logic [WORD_SIZE-1:0] mem_word;
   logic [7:0]           byte_val;
   logic [15:0]          half_val;
   logic                 unused_addr_bits;

   logic                 load_ok;
   logic [WORD_SIZE-1:0] load_val;
   logic                 store_ok;
   logic [WORD_SIZE-1:0] merged_word;

   logic                 rf_wen;
   logic [WORD_SIZE-1:0] rf_wdata;
   logic                 mem_wen;

   assign opcode    = instr[6:0];
   assign rd        = instr[11:7];
   assign funct3    = instr[14:12];
   assign rs1       = instr[19:15];
   assign rs2       = instr[24:20];
   assign imm_i_val = imm_i(instr);
   assign imm_s_val = imm_s(instr);

   assign rs1_val = (rs1 == 5'd0) ? '0 : regfile[rs1];
   assign rs2_val = (rs2 == 5'd0) ? '0 : regfile[rs2];

   sodor5_isa_alu u_alu (
      .funct3 (funct3),
      .alt    (instr[30]),
      .a      (rs1_val),
      .imm    (imm_i_val),
      .result (alu_result)
   );

   // Addresses wrap modulo the memory size: only the word-index bits matter.
   assign eff_addr         = rs1_val + ((opcode == OPC_STORE) ? imm_s_val : imm_i_val);
   assign word_idx         = eff_addr[DAW+1:2];
   assign byte_off         = {eff_addr[1:0], 3'b000};
   assign half_off         = {eff_addr[1], 4'b0000};
   assign unused_addr_bits = ^eff_addr[WORD_SIZE-1:DAW+2];
   assign mem_word         = mem[word_idx];
   assign byte_val         = mem_word[byte_off +: 8];
   assign half_val         = mem_word[half_off +: 16];

   always_comb begin
      load_ok  = 1'b1;
      load_val = '0;
      case (funct3)
         F3_LB:   load_val = {{(WORD_SIZE-8){byte_val[7]}}, byte_val};
         F3_LBU:  load_val = {{(WORD_SIZE-8){1'b0}}, byte_val};
         F3_LH:   load_val = {{(WORD_SIZE-16){half_val[15]}}, half_val};
         F3_LHU:  load_val = {{(WORD_SIZE-16){1'b0}}, half_val};
         F3_LW:   load_val = mem_word;
         default: load_ok  = 1'b0;
      endcase
   end

   always_comb begin
      store_ok    = 1'b1;
      merged_word = mem_word;
      case (funct3)
         F3_SB:   merged_word[byte_off +: 8]  = rs2_val[7:0];
         F3_SH:   merged_word[half_off +: 16] = rs2_val[15:0];
         F3_SW:   merged_word                 = rs2_val;
         default: store_ok                    = 1'b0;
      endcase
   end

   always_comb begin
      rf_wen   = 1'b0;
      rf_wdata = '0;
      mem_wen  = 1'b0;
      case (opcode)
         OPC_OPIMM: begin
            rf_wen   = (rd != 5'd0);
            rf_wdata = alu_result;
         end
         OPC_LOAD: begin
            rf_wen   = load_ok && (rd != 5'd0);
            rf_wdata = load_val;
         end
         OPC_STORE: begin
            mem_wen  = store_ok;
         end
         default: begin
            rf_wen   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (rf_wen) begin
            regfile[rd] <= rf_wdata;
         end
         if (mem_wen) begin
            mem[word_idx] <= merged_word;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg     <= '0;
         commit_reg <= '0;
      end else begin
         pc_reg                 <= pc_reg + WORD_SIZE'(4);
         commit_reg.valid       <= 1'b1;
         commit_reg.pc          <= pc_reg;
         commit_reg.wen         <= rf_wen;
         commit_reg.rd          <= rf_wen ? rd : 5'd0;
         commit_reg.wdata       <= rf_wen ? rf_wdata : '0;
         commit_reg.store_en    <= mem_wen;
         commit_reg.store_addr  <= mem_wen ? eff_addr : '0;
         commit_reg.store_wdata <= mem_wen ? merged_word : '0;
      end
   end

   assign commit_valid = commit_reg.valid;
   assign commit_pc    = commit_reg.pc;
   assign commit_wen   = commit_reg.wen;
   assign commit_rd    = commit_reg.rd;
   assign commit_wdata = commit_reg.wdata;
   assign store_en     = commit_reg.store_en;
   assign store_addr   = commit_reg.store_addr;
   assign store_wdata  = commit_reg.store_wdata;

endmodule

// File: tb/tb_sodor5_isa_ref_model.sv
// Scoreboard bench: the driver runs each instruction through an arithmetic
// ISA model and queues the expected commit; the monitor pops and compares.
module tb_sodor5_isa_ref_model;

   localparam logic [6:0] OP_IMM = 7'h13;
   localparam logic [6:0] OP_LD  = 7'h03;
   localparam logic [6:0] OP_ST  = 7'h23;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr = 32'h0000_0013;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        commit_wen;
   logic [4:0]  commit_rd;
   logic [31:0] commit_wdata;
   logic        store_en;
   logic [31:0] store_addr;
   logic [31:0] store_wdata;

   always #5 clk = ~clk;

   sodor5_isa_ref_model dut (
      .clk          (clk),
      .reset        (reset),
      .instr        (instr),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .commit_wen   (commit_wen),
      .commit_rd    (commit_rd),
      .commit_wdata (commit_wdata),
      .store_en     (store_en),
      .store_addr   (store_addr),
      .store_wdata  (store_wdata)
   );

   typedef struct {
      logic [31:0] pc;
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] wdata;
      logic        st;
      logic [31:0] saddr;
      logic [31:0] swdata;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [31:0] m_regs [32];
   logic [31:0] m_mem  [16];
   logic [31:0] m_pc = 32'h0;
   int          n_vec  = 0;
   int          n_fail = 0;
   logic [6:0]  other_opc [5] = '{7'h33, 7'h37, 7'h6F, 7'h63, 7'h00};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %08h, required %08h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] rreg(input logic [4:0] r);
      return (r == 5'd0) ? 32'h0 : m_regs[r];
   endfunction

   // ISA rules expressed with plain arithmetic on the model's own state.
   function automatic exp_t model_exec(input logic [31:0] ins);
      exp_t        e;
      logic [31:0] a, b, ii, is, r, ad, w, v, mask, data;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        wr;
      int          sh, idx;
      a  = rreg(ins[19:15]);
      b  = rreg(ins[24:20]);
      ii = {{20{ins[31]}}, ins[31:20]};
      is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      f3 = ins[14:12];
      rd = ins[11:7];
      r  = 32'h0;
      wr = 1'b0;
      e  = '{pc: m_pc, wen: 1'b0, rd: 5'd0, wdata: 32'h0, st: 1'b0, saddr: 32'h0, swdata: 32'h0};
      m_pc = m_pc + 32'd4;
      if (ins[6:0] == OP_IMM) begin
         sh = int'(ins[24:20]);
         wr = 1'b1;
         case (f3)
            3'd0: r = a + ii;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
            3'd3: r = (a < ii) ? 32'd1 : 32'd0;
            3'd4: r = a ^ ii;
            3'd5: begin
               r = a >> sh;
               if (ins[30] && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: r = a | ii;
            default: r = a & ii;
         endcase
      end else if (ins[6:0] == OP_LD) begin
         ad  = a + ii;
         idx = int'((ad >> 2) & 32'hF);
         w   = m_mem[idx];
         sh  = 8 * int'(ad & 32'd3);
         wr  = 1'b1;
         case (f3)
            3'd0, 3'd4: begin
               v = (w >> sh) & 32'hFF;
               if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
               r = v;
            end
            3'd1, 3'd5: begin
               v = (w >> (16 * int'((ad >> 1) & 32'd1))) & 32'hFFFF;
               if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
               r = v;
            end
            3'd2: r = w;
            default: wr = 1'b0;
         endcase
      end else if (ins[6:0] == OP_ST && f3 <= 3'd2) begin
         ad  = a + is;
         idx = int'((ad >> 2) & 32'hF);
         w   = m_mem[idx];
         sh  = 8 * int'(ad & 32'd3);
         if (f3 == 3'd0) begin
            mask = 32'hFF << sh;
            data = b << sh;
         end else if (f3 == 3'd1) begin
            sh   = 16 * int'((ad >> 1) & 32'd1);
            mask = 32'hFFFF << sh;
            data = b << sh;
         end else begin
            mask = 32'hFFFF_FFFF;
            data = b;
         end
         m_mem[idx] = (w & ~mask) | (data & mask);
         e.st       = 1'b1;
         e.saddr    = ad;
         e.swdata   = m_mem[idx];
      end
      if (wr && rd != 5'd0) begin
         m_regs[rd] = r;
         e.wen      = 1'b1;
         e.rd       = rd;
         e.wdata    = r;
      end
      return e;
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_ST};
   endfunction

   // use_lit replaces the model's data value with a hand-derived constant.
   task automatic issue_x(input logic [31:0] ins, input logic use_lit, input logic [31:0] lit);
      exp_t e;
      @(negedge clk);
      e = model_exec(ins);
      if (use_lit) begin
         if (e.st) e.swdata = lit;
         else      e.wdata  = lit;
      end
      sb_q.push_back(e);
      instr = ins;
      reset = 1'b0;
   endtask

   task automatic issue(input logic [31:0] ins);
      issue_x(ins, 1'b0, 32'h0);
   endtask

   task automatic issue_lit(input logic [31:0] ins, input logic [31:0] lit);
      issue_x(ins, 1'b1, lit);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, {31'b0, commit_valid}, 32'h0);
      check({tag, "_wen"},   {31'b0, commit_wen},   32'h0);
      check({tag, "_st"},    {31'b0, store_en},     32'h0);
      check({tag, "_pc"},    commit_pc,             32'h0);
      check({tag, "_wdata"}, commit_wdata,          32'h0);
   endtask

   task automatic reset_pulse(input int cycles);
      @(negedge clk);
      reset = 1'b1;
      m_pc  = 32'h0;
      #1;
      check_reset_outputs("midreset");
      $display("reset asserted for %0d cycles", cycles);
      repeat (cycles) @(negedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      if (commit_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_commit: got commit at pc %08h, required none", commit_pc);
         end else begin
            mon_e = sb_q.pop_front();
            check("commit_pc",  commit_pc,           mon_e.pc);
            check("commit_wen", {31'b0, commit_wen}, {31'b0, mon_e.wen});
            check("store_en",   {31'b0, store_en},   {31'b0, mon_e.st});
            if (mon_e.wen) begin
               check("commit_rd",    {27'b0, commit_rd}, {27'b0, mon_e.rd});
               check("commit_wdata", commit_wdata,       mon_e.wdata);
            end
            if (mon_e.st) begin
               check("store_addr",  store_addr,  mon_e.saddr);
               check("store_wdata", store_wdata, mon_e.swdata);
            end
            $display("commit pc=%08h wen=%0d rd=%0d wdata=%08h st=%0d addr=%08h sdata=%08h",
                     commit_pc, commit_wen, commit_rd, commit_wdata, store_en, store_addr, store_wdata);
         end
      end else if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         n_vec++;
         n_fail++;
         $display("FAIL missing_commit: got commit_valid=%0b, required commit for pc %08h",
                  commit_valid, mon_e.pc);
      end
   end

   initial begin
      logic [31:0] ins;
      for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
      for (int k = 0; k < 16; k++) m_mem[k] = 32'h0;

      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");

      // Give every register and memory word a defined value.
      for (int k = 1; k < 32; k++) issue(enc_i(12'd0, 5'd0, 3'd0, 5'(k), OP_IMM));
      for (int i = 0; i < 16; i++) begin
         issue(enc_i(12'(i), 5'd0, 3'd0, 5'd1, OP_IMM));
         repeat (7) begin
            issue(enc_i(12'd4, 5'd1, 3'd1, 5'd1, OP_IMM));
            issue(enc_i(12'(i), 5'd1, 3'd6, 5'd1, OP_IMM));
         end
         issue(enc_s(12'(4 * i), 5'd1, 5'd0, 3'd2));
      end

      reset_pulse(2);
      issue_lit(enc_i(12'd5,     5'd0, 3'd0, 5'd2,  OP_LD),  32'h0000_0011);
      issue_lit(enc_i(12'h020,   5'd0, 3'd0, 5'd5,  OP_LD),  32'hFFFF_FF88);
      issue_lit(enc_i(12'h021,   5'd0, 3'd4, 5'd6,  OP_LD),  32'h0000_0088);
      issue_lit(enc_i(12'h03C,   5'd0, 3'd2, 5'd7,  OP_LD),  32'hFFFF_FFFF);
      issue_lit(enc_i(12'hFFF,   5'd0, 3'd0, 5'd3,  OP_IMM), 32'hFFFF_FFFF);
      issue_lit(enc_i(12'h004,   5'd3, 3'd5, 5'd4,  OP_IMM), 32'h0FFF_FFFF);
      issue_lit(enc_i(12'h404,   5'd3, 3'd5, 5'd4,  OP_IMM), 32'hFFFF_FFFF);
      issue_lit(enc_i(12'hFFF,   5'd0, 3'd3, 5'd8,  OP_IMM), 32'h0000_0001);
      issue_lit(enc_s(12'd2,     5'd3, 5'd0, 3'd0),          32'h00FF_0000);
      issue_lit(enc_i(12'd2,     5'd0, 3'd4, 5'd9,  OP_LD),  32'h0000_00FF);
      issue(enc_i(12'd5,         5'd0, 3'd0, 5'd0,  OP_IMM));
      issue_lit(enc_i(12'd7,     5'd0, 3'd0, 5'd10, OP_IMM), 32'h0000_0007);
      issue_lit(enc_i(12'h044,   5'd0, 3'd2, 5'd11, OP_LD),  32'h1111_1111);
      issue(32'h0000_0013);

      reset_pulse(3);
      issue_lit(enc_i(12'd8,     5'd0, 3'd2, 5'd12, OP_LD),  32'h2222_2222);
      issue_lit(enc_i(12'd0,     5'd9, 3'd0, 5'd13, OP_IMM), 32'h0000_00FF);

      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 3))
            0: ins = enc_i(12'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), OP_IMM);
            1: ins = enc_i(12'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), OP_LD);
            2: ins = enc_s(12'($urandom), 5'($urandom), 5'($urandom), 3'($urandom_range(0, 2)));
            default: begin
               ins      = $urandom;
               ins[6:0] = other_opc[$urandom_range(0, 4)];
            end
         endcase
         issue(ins);
         if ($urandom_range(0, 59) == 0) reset_pulse($urandom_range(1, 3));
      end

      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
